// File: rtl/cgemm_beat_packer.sv
// rtl/cgemm_beat_packer.sv - joins A/B vectors into framed beats sent over rts/rtr
module cgemm_beat_packer #(
  parameter int DATA_WIDTH     = 1024,
  parameter int ARITH_IN_WIDTH = 16,
  parameter int N              = 32,
  parameter int M              = 31,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [CNT_WIDTH-1:0]        k_len_i,
  input  logic [CNT_WIDTH-1:0]        n_blocks_i,
  input  logic                        a_valid_i,
  output logic                        a_ready_o,
  input  logic [N*ARITH_IN_WIDTH-1:0] a_data_i,
  input  logic                        b_valid_i,
  output logic                        b_ready_o,
  input  logic [M*ARITH_IN_WIDTH-1:0] b_data_i,
  output logic                        rts_o,
  input  logic                        rtr_i,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int AW = N * ARITH_IN_WIDTH;
  localparam int BW = M * ARITH_IN_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  // Both vectors plus the two flag bits must fit in one beat.
  generate
    if (AW + BW > DATA_WIDTH - 2) begin : g_width_check
      $fatal(1, "cgemm_beat_packer: A+B vectors do not fit in DATA_WIDTH-2 bits");
    end
  endgenerate

  logic [1:0]            state;
  logic [CNT_WIDTH-1:0]  k_len;
  logic [CNT_WIDTH-1:0]  n_blocks;
  logic [CNT_WIDTH-1:0]  beat_cnt;
  logic [CNT_WIDTH-1:0]  blk_cnt;
  logic [DATA_WIDTH-1:0] buf_head;
  logic [DATA_WIDTH-1:0] buf_tail;
  logic [1:0]            buf_cnt;
  logic [DATA_WIDTH-1:0] beat;
  logic                  fire;
  logic                  pop;
  logic                  last_beat;
  logic                  last_blk;

  assign last_beat = (beat_cnt == k_len - CNT_ONE);
  assign last_blk  = (blk_cnt == n_blocks - CNT_ONE);

  // Acceptance looks only at the registered occupancy, never at rtr_i.
  assign fire      = ~rst & (state == ST_RUN) & a_valid_i & b_valid_i & (buf_cnt != 2'd2);
  assign pop       = rts_o & rtr_i;
  assign a_ready_o = fire;
  assign b_ready_o = fire;
  assign rts_o     = (buf_cnt != 2'd0);
  assign data_o    = buf_head;
  assign busy_o    = (state != ST_IDLE);

  // Assemble the outgoing beat: A low, B above it, zero pad, SOB/EOB on top.
  always_comb begin
    beat                       = '0;
    beat[AW-1:0]               = a_data_i;
    beat[AW+BW-1:AW]           = b_data_i;
    beat[DATA_WIDTH-2]         = (beat_cnt == '0);
    beat[DATA_WIDTH-1]         = last_beat;
  end

  // Job sequencing: latch sizes on start, count beats/blocks, wait for drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      k_len    <= '0;
      n_blocks <= '0;
      beat_cnt <= '0;
      blk_cnt  <= '0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            k_len    <= k_len_i;
            n_blocks <= n_blocks_i;
            beat_cnt <= '0;
            blk_cnt  <= '0;
            state    <= ((k_len_i == '0) || (n_blocks_i == '0)) ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (fire) begin
            if (last_beat) begin
              beat_cnt <= '0;
              blk_cnt  <= blk_cnt + CNT_ONE;
              if (last_blk) begin
                state <= ST_DRAIN;
              end
            end else begin
              beat_cnt <= beat_cnt + CNT_ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (buf_cnt == 2'd0) begin
            done_o <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Two-entry output FIFO; the head register drives data_o directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_head <= '0;
      buf_tail <= '0;
      buf_cnt  <= 2'd0;
    end else begin
      case ({fire, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) begin
            buf_head <= beat;
          end else begin
            buf_tail <= beat;
          end
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf_head <= buf_tail;
          buf_cnt  <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf_head <= beat;
          end else begin
            buf_head <= buf_tail;
            buf_tail <= beat;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cgemm_beat_packer.sv
// tb/tb_cgemm_beat_packer.sv - randomized bench for cgemm_beat_packer against a beat-list model
module tb_cgemm_beat_packer;

  localparam int DW  = 1024;
  localparam int W   = 16;
  localparam int N   = 32;
  localparam int M   = 31;
  localparam int CW  = 16;
  localparam int AW  = N * W;
  localparam int BW  = M * W;
  localparam int PAD = DW - 2 - AW - BW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [CW-1:0] k_len_i = '0;
  logic [CW-1:0] n_blocks_i = '0;
  logic          a_valid_i = 1'b0;
  logic          a_ready_o;
  logic [AW-1:0] a_data_i = '0;
  logic          b_valid_i = 1'b0;
  logic          b_ready_o;
  logic [BW-1:0] b_data_i = '0;
  logic          rts_o;
  logic          rtr_i = 1'b0;
  logic [DW-1:0] data_o;
  logic          busy_o;
  logic          done_o;

  cgemm_beat_packer #(
    .DATA_WIDTH(DW), .ARITH_IN_WIDTH(W), .N(N), .M(M), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .k_len_i(k_len_i), .n_blocks_i(n_blocks_i),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_data_i(a_data_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_data_i(b_data_i),
    .rts_o(rts_o), .rtr_i(rtr_i), .data_o(data_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: the job is a list of source pairs; the output
  // buffer is just the list of beats accepted but not yet delivered.
  logic [AW-1:0] src_a[$];
  logic [BW-1:0] src_b[$];
  logic [DW-1:0] exp_q[$];
  int  kk, total, cons, popped, obs, mode;
  int  since_drain, first_pop, last_pop, done_seen;
  bit  running, in_job, hold;
  logic [DW-1:0] hold_data;

  function automatic logic [AW-1:0] rand_a();
    logic [AW-1:0] v;
    for (int i = 0; i < AW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [BW-1:0] rand_b();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v[BW-1:0];
  endfunction

  function automatic logic [DW-1:0] make_beat(input int i);
    int p;
    p = i % kk;
    return {(p == kk - 1), (p == 0), {PAD{1'b0}}, src_b[i], src_a[i]};
  endfunction

  task automatic cycle(input bit do_start, input int ks, input int ns);
    bit av, bv, rt, exp_ready;
    logic [DW-1:0] e;
    @(negedge clk);
    obs++;
    if (since_drain >= 0) since_drain++;
    case (mode)
      0: begin av = 1; bv = 1; rt = 1; end
      1: begin av = 1; bv = 1; rt = !(obs >= 4 && obs < 9); end
      2: begin av = 1; bv = (obs >= 4); rt = 1; end
      default: begin
        av = ($urandom_range(0, 3) != 0);
        bv = ($urandom_range(0, 3) != 0);
        rt = ($urandom_range(0, 2) != 0);
      end
    endcase
    a_valid_i = av;
    b_valid_i = bv;
    rtr_i     = rt;
    if (do_start) begin
      start_i = 1; k_len_i = CW'(ks); n_blocks_i = CW'(ns);
    end else if (in_job && since_drain != 2 &&
                 ((mode == 1 && obs == 2) || (mode == 3 && $urandom_range(0, 9) == 0))) begin
      start_i = 1; k_len_i = 9; n_blocks_i = 1;
    end else begin
      start_i = 0; k_len_i = CW'($urandom); n_blocks_i = CW'($urandom);
    end
    a_data_i = (cons < total) ? src_a[cons] : rand_a();
    b_data_i = (cons < total) ? src_b[cons] : rand_b();
    #1;
    exp_ready = running && av && bv && (exp_q.size() < 2);
    check("a_ready", a_ready_o, exp_ready);
    check("b_ready", b_ready_o, exp_ready);
    check("rts", rts_o, exp_q.size() != 0);
    check("busy", busy_o, in_job && since_drain != 2);
    check("done", done_o, since_drain == 2);
    if (done_o) done_seen++;
    if (hold) begin
      check("hold_rts", rts_o, 1'b1);
      check("hold_data_lo", data_o[511:0], hold_data[511:0]);
      check("hold_data_hi", data_o[DW-1:512], hold_data[DW-1:512]);
    end
    hold = 0;
    if (exp_q.size() != 0) begin
      if (rt) begin
        e = exp_q.pop_front();
        check("beat_a", data_o[AW-1:0], e[AW-1:0]);
        check("beat_b", data_o[AW+BW-1:AW], e[AW+BW-1:AW]);
        check("beat_flags_pad", data_o[DW-1:AW+BW], e[DW-1:AW+BW]);
        popped++;
        if (first_pop < 0) first_pop = obs;
        last_pop = obs;
      end else begin
        hold = 1;
        hold_data = data_o;
      end
    end
    if (exp_ready) begin
      exp_q.push_back(make_beat(cons));
      cons++;
      if (cons == total) running = 0;
    end
    if (since_drain == 2) begin
      in_job = 0;
      since_drain = -1;
    end else if (in_job && !running && exp_q.size() == 0 && since_drain < 0) begin
      since_drain = 0;
    end
  endtask

  task automatic setup_job(input int k, input int n, input int m);
    src_a.delete(); src_b.delete(); exp_q.delete();
    kk = k; total = k * n; mode = m;
    for (int i = 0; i < total; i++) begin
      src_a.push_back(rand_a());
      src_b.push_back(rand_b());
    end
    cons = 0; popped = 0; obs = -1; since_drain = -1;
    first_pop = -1; last_pop = -1; done_seen = 0;
    running = 0; in_job = 0; hold = 0;
    cycle(1, k, n);
    in_job = 1;
    running = (total > 0);
    if (total == 0) since_drain = 0;
  endtask

  task automatic run_job(input int k, input int n, input int m);
    int guard;
    setup_job(k, n, m);
    guard = 0;
    while (in_job && guard < 3000) begin
      cycle(0, 0, 0);
      guard++;
    end
    check("job_timeout", in_job, 1'b0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("beats_popped", popped, total);
    check("done_pulses", done_seen, 1);
    if (m == 0 && total > 0) begin
      check("first_beat_latency", first_pop, 2);
      check("back_to_back", last_pop - first_pop, total - 1);
    end
  endtask

  task automatic reset_mid_job();
    int guard;
    setup_job(4, 1, 0);
    guard = 0;
    while (popped < 2 && guard < 100) begin
      cycle(0, 0, 0);
      guard++;
    end
    check("mid_job_progress", popped, 2);
    @(negedge clk);
    rst = 1; start_i = 0;
    @(negedge clk);
    rst = 0;
    #1;
    check("rst_rts", rts_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_ready", a_ready_o, 1'b0);
    exp_q.delete();
    in_job = 0; running = 0; hold = 0; since_drain = -1; done_seen = 0;
    total = 0; cons = 0;
    repeat (4) cycle(0, 0, 0);
    check("rst_no_done", done_seen, 0);
  endtask

  initial begin
    rst = 1;
    a_valid_i = 1; b_valid_i = 1; rtr_i = 1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_rts", rts_o, 1'b0);
    check("reset_data_lo", data_o[511:0], '0);
    check("reset_data_hi", data_o[DW-1:512], '0);
    check("reset_busy", busy_o, 1'b0);
    check("reset_done", done_o, 1'b0);
    check("reset_a_ready", a_ready_o, 1'b0);
    check("reset_b_ready", b_ready_o, 1'b0);
    rst = 0;

    run_job(4, 2, 0);
    run_job(4, 2, 1);
    run_job(4, 2, 2);
    run_job(1, 3, 0);
    run_job(0, 3, 0);
    run_job(3, 0, 0);
    run_job(4, 2, 3);
    reset_mid_job();
    run_job(4, 1, 0);
    for (int j = 0; j < 8; j++) begin
      run_job($urandom_range(1, 6), $urandom_range(1, 4), 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cgemm_beat_packer.md
Name: cgemm_beat_packer

Overview:
- Host-side transmitter for the systolic-array stream interface: joins one A-row vector and one B-column vector per beat into a DATA_WIDTH beat.
- Tags each beat with start-of-block (bit DATA_WIDTH-2) and end-of-block (bit DATA_WIDTH-1) flags, then sends it over the rts/rtr handshake to the SA wrapper's slave side.
- Sits between the DMA read path and the SA wrapper; owns all block framing so the SA never receives a malformed block.

Parameters:
- DATA_WIDTH, 1024, output beat width.
- ARITH_IN_WIDTH, 16, width of one arithmetic element.
- N, 32, elements per A vector.
- M, 31, elements per B vector.
- CNT_WIDTH, 16, width of the k_len and n_blocks counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle pulse; launches a job; ignored unless busy_o=0.
- k_len_i  in  CNT_WIDTH  beats per block; sampled at start.
- n_blocks_i  in  CNT_WIDTH  blocks per job; sampled at start.
- a_valid_i  in  1  A vector valid.
- a_ready_o  out  1  A vector consumed.
- a_data_i  in  N*ARITH_IN_WIDTH  A row vector.
- b_valid_i  in  1  B vector valid.
- b_ready_o  out  1  B vector consumed.
- b_data_i  in  M*ARITH_IN_WIDTH  B column vector.
- rts_o  out  1  output beat valid (ready-to-send).
- rtr_i  in  1  downstream ready-to-receive.
- data_o  out  DATA_WIDTH  packed beat.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle pulse at job completion.

Behaviour:
- Elaboration check: (N+M)*ARITH_IN_WIDTH <= DATA_WIDTH-2; otherwise $fatal.
- Beat layout:
  - [N*W-1:0] = a_data_i.
  - [(N+M)*W-1:N*W] = b_data_i.
  - Bits from (N+M)*W through DATA_WIDTH-3 are zero.
  - Bit DATA_WIDTH-2 = SOB; bit DATA_WIDTH-1 = EOB.
- Reset (synchronous): state=IDLE, counters=0, output buffer emptied. Registered outputs after the edge: rts_o=0, data_o=0, busy_o=0, done_o=0. Ports a_ready_o and b_ready_o evaluate to 0.
- FSM:
  - IDLE: on start_i, latch k_len_i and n_blocks_i. If either is 0, go to DRAIN (zero-beat job). Otherwise go to RUN.
  - RUN: fire = a_valid_i & b_valid_i & (buf_cnt<2).
    - a_ready_o = b_ready_o = fire. A and B are consumed jointly; a lone valid never consumes.
    - On fire, push a beat; beat_cnt++.
    - When beat_cnt==k_len-1, wrap beat_cnt to 0 and increment blk_cnt.
    - Firing the last beat of the last block moves to DRAIN.
  - DRAIN: wait for buf_cnt==0, then pulse done_o for 1 cycle and return to IDLE.
- Flags:
  - SOB=1 when beat_cnt==0.
  - EOB=1 when beat_cnt==k_len-1.
  - k_len=1 sets both flags on every beat.
- busy_o=1 in RUN and DRAIN.
- Output buffer: 2-entry FIFO; rts_o = buffer not empty; data_o = head entry, registered.
  - Pop on rts_o & rtr_i.
  - Push and pop in the same cycle leave buf_cnt unchanged.
- Acceptance uses registered buf_cnt only, so there is no combinational path from rtr_i to a_ready_o or b_ready_o.
- Sustains 1 beat/clk when rtr_i is held high.
- Once rts_o=1, data_o stays stable and rts_o stays high until popped; it never retracts.
- Latency: a beat fired at cycle t appears with rts_o=1 at t+1 if the buffer was empty.
- A start_i pulse while busy_o=1 is ignored, with no side effects.
- Reset mid-job aborts the job: no done_o, and in-flight beats are discarded.
- Counter wrap is defined by k_len and n_blocks only; no overflow is possible within CNT_WIDTH.

Test Plan:
- Basic job: k_len=4, n_blocks=2, A/B always valid, rtr_i=1 -> 8 beats on consecutive cycles. SOB on beats 0 and 4, EOB on beats 3 and 7. data_o[1007:0] = {B,A}, bits 1021:1008 = 0. done_o pulses 1 cycle after beat 7 is popped.
- Backpressure: same job with rtr_i low for 5 cycles mid-job -> a_ready_o drops after 2 buffered beats. data_o and rts_o are stable while stalled. No beat is lost or duplicated: output sequence equals input sequence.
- Skewed inputs: b_valid_i arrives 3 cycles after a_valid_i -> nothing is consumed until both are valid; the beat pairs A(i) with B(i).
- Degenerate sizes: k_len=1, n_blocks=3 -> 3 beats, each with SOB=EOB=1. k_len=0 -> no rts_o, done_o 2 cycles after start.
- Start while busy: pulse start_i during RUN with new k_len=9 -> the running job completes with its original k_len and no second done_o.
- Reset mid-job: assert rst after 2 of 4 beats -> next cycle rts_o=0, busy_o=0, and no done_o. A fresh start then produces a correct job beginning with SOB.
